// File: rtl/knight_cmd_proc.sv
// Knight command processor: consumes wrapper commands (clr_cmd_rdy same cycle, moving one cycle later) and sequences cal/turn/move.
// Commands arriving mid-operation are held until IDLE; optional fanfare pulse on opcode 5 is built when KNIGHT_FANFARE_EN is defined.
module knight_cmd_proc #(
  parameter bit          FAST_SIM   = 1'b1,
  parameter logic [11:0] ERR_THRESH = 12'h030,
  parameter logic [9:0]  FRWRD_MAX  = 10'h300
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd,
  input  logic        cmd_rdy,
  output logic        clr_cmd_rdy,
  input  logic [11:0] heading,
  input  logic        heading_rdy,
  input  logic        cal_done,
  input  logic        cntrIR,
  output logic        strt_cal,
  output logic        tour_go,
  output logic [11:0] desired_heading,
  output logic [9:0]  frwrd,
  output logic        moving,
  output logic        send_resp,
  output logic        fanfare_go
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAL     = 3'd1,
    TURN    = 3'd2,
    RAMP_UP = 3'd3,
    RAMP_DN = 3'd4
  } state_t;

  localparam logic [3:0] OP_CAL     = 4'h2;
  localparam logic [3:0] OP_MOVE    = 4'h4;
  localparam logic [3:0] OP_MOVE_FF = 4'h5;
  localparam logic [3:0] OP_TOUR    = 4'h6;

  localparam logic [9:0] INC = FAST_SIM ? 10'h020 : 10'h003;
  localparam logic [9:0] DEC = {INC[8:0], 1'b0};

  state_t      state_q, state_d;
  logic [11:0] desired_heading_q, desired_heading_d;
  logic [9:0]  frwrd_q, frwrd_d;
  logic [4:0]  line_cnt_q, line_cnt_d;
  logic [3:0]  sq_target_q, sq_target_d;
  logic        moving_q, moving_d;
  logic        cntr_meta_q, cntr_meta_d;
  logic        cntr_sync_q, cntr_sync_d;
  logic        cntr_prev_q, cntr_prev_d;
`ifdef KNIGHT_FANFARE_EN
  logic        fanfare_q, fanfare_d;
`endif

  logic [11:0] err;
  logic [11:0] err_abs;
  logic        aligned;
  logic [10:0] up_sum;
  logic [9:0]  frwrd_inc;
  logic [9:0]  frwrd_dec;
  logic [4:0]  line_tgt;
  logic        cntr_rise;
  logic        move_done;

  // Heading error wraps modulo 4096, so the magnitude is taken on the signed 12-bit difference.
  assign err       = heading - desired_heading_q;
  assign err_abs   = err[11] ? (~err + 12'd1) : err;
  assign aligned   = (err_abs < ERR_THRESH);

  assign up_sum    = {1'b0, frwrd_q} + {1'b0, INC};
  assign frwrd_inc = (up_sum > {1'b0, FRWRD_MAX}) ? FRWRD_MAX : up_sum[9:0];
  assign frwrd_dec = (frwrd_q < DEC) ? 10'h000 : (frwrd_q - DEC);

  // Two lines per square: start braking after the first line of the last square.
  assign line_tgt  = {sq_target_q, 1'b0} - 5'd1;
  assign cntr_rise = cntr_sync_q & ~cntr_prev_q;

  always_comb begin
    state_d           = state_q;
    desired_heading_d = desired_heading_q;
    frwrd_d           = frwrd_q;
    line_cnt_d        = line_cnt_q;
    sq_target_d       = sq_target_q;
    moving_d          = moving_q;
    cntr_meta_d       = cntrIR;
    cntr_sync_d       = cntr_meta_q;
    cntr_prev_d       = cntr_sync_q;
`ifdef KNIGHT_FANFARE_EN
    fanfare_d         = fanfare_q;
`endif
    clr_cmd_rdy       = 1'b0;
    strt_cal          = 1'b0;
    tour_go           = 1'b0;
    send_resp         = 1'b0;
    move_done         = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_rdy) begin
          clr_cmd_rdy = 1'b1;
          case (cmd[15:12])
            OP_CAL: begin
              strt_cal = 1'b1;
              state_d  = CAL;
            end
            OP_MOVE, OP_MOVE_FF: begin
              desired_heading_d = (cmd[11:4] == 8'h00) ? 12'h000 : {cmd[11:4], 4'hF};
              sq_target_d       = cmd[3:0];
              line_cnt_d        = 5'd0;
              moving_d          = 1'b1;
              state_d           = TURN;
`ifdef KNIGHT_FANFARE_EN
              fanfare_d         = (cmd[15:12] == OP_MOVE_FF);
`endif
            end
            OP_TOUR: tour_go = 1'b1;
            default: ;
          endcase
        end
      end
      CAL: begin
        if (cal_done) begin
          send_resp = 1'b1;
          state_d   = IDLE;
        end
      end
      TURN: begin
        frwrd_d = 10'h000;
        if (heading_rdy && aligned) begin
          if (sq_target_q == 4'd0) move_done = 1'b1;
          else                     state_d   = RAMP_UP;
        end
      end
      RAMP_UP: begin
        if (heading_rdy) frwrd_d = frwrd_inc;
        if (line_cnt_q == line_tgt) state_d = RAMP_DN;
      end
      RAMP_DN: begin
        if (heading_rdy) frwrd_d = frwrd_dec;
        if (frwrd_q == 10'h000) move_done = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if ((state_q == RAMP_UP || state_q == RAMP_DN) && cntr_rise)
      line_cnt_d = line_cnt_q + 5'd1;

    if (move_done) begin
      send_resp = 1'b1;
      moving_d  = 1'b0;
      frwrd_d   = 10'h000;
      state_d   = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      desired_heading_q <= 12'h000;
      frwrd_q           <= 10'h000;
      line_cnt_q        <= 5'd0;
      sq_target_q       <= 4'd0;
      moving_q          <= 1'b0;
      cntr_meta_q       <= 1'b0;
      cntr_sync_q       <= 1'b0;
      cntr_prev_q       <= 1'b0;
    end else begin
      state_q           <= state_d;
      desired_heading_q <= desired_heading_d;
      frwrd_q           <= frwrd_d;
      line_cnt_q        <= line_cnt_d;
      sq_target_q       <= sq_target_d;
      moving_q          <= moving_d;
      cntr_meta_q       <= cntr_meta_d;
      cntr_sync_q       <= cntr_sync_d;
      cntr_prev_q       <= cntr_prev_d;
    end
  end

`ifdef KNIGHT_FANFARE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fanfare_q <= 1'b0;
    else        fanfare_q <= fanfare_d;
  end

  assign fanfare_go = move_done & fanfare_q;
`else
  assign fanfare_go = 1'b0;
`endif

  assign desired_heading = desired_heading_q;
  assign frwrd           = frwrd_q;
  assign moving          = moving_q;

endmodule

// File: tb/tb_knight_cmd_proc.sv
// Directed bench for knight_cmd_proc: calibration, turn/move sequencing, held commands, async reset.
module tb_knight_cmd_proc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cmd = 16'h0000;
  logic        cmd_rdy = 1'b0;
  logic        clr_cmd_rdy;
  logic [11:0] heading = 12'h000;
  logic        heading_rdy = 1'b0;
  logic        cal_done = 1'b0;
  logic        cntrIR = 1'b0;
  logic        strt_cal;
  logic        tour_go;
  logic [11:0] desired_heading;
  logic [9:0]  frwrd;
  logic        moving;
  logic        send_resp;
  logic        fanfare_go;

  int total = 0;
  int bad = 0;
  int resp_cnt = 0;
  int ff_cnt = 0;
  int ff_coinc = 0;
  int clr_cnt = 0;
  bit frwrd_nz = 1'b0;

  knight_cmd_proc dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
    .heading(heading), .heading_rdy(heading_rdy), .cal_done(cal_done), .cntrIR(cntrIR),
    .strt_cal(strt_cal), .tour_go(tour_go), .desired_heading(desired_heading),
    .frwrd(frwrd), .moving(moving), .send_resp(send_resp), .fanfare_go(fanfare_go)
  );

  always #5 clk = ~clk;

  // Per-cycle event counters, sampled mid-cycle once inputs have settled.
  always @(negedge clk) begin
    #2;
    if (send_resp) resp_cnt++;
    if (fanfare_go) ff_cnt++;
    if (fanfare_go && send_resp) ff_coinc++;
    if (clr_cmd_rdy) clr_cnt++;
    if (frwrd != 10'h000) frwrd_nz = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input logic [15:0] c, input string tag);
    @(negedge clk);
    cmd = c;
    cmd_rdy = 1'b1;
    #1;
    chk(tag, clr_cmd_rdy, 1);
    @(negedge clk);
    cmd_rdy = 1'b0;
  endtask

  task automatic hpulse();
    @(negedge clk);
    heading_rdy = 1'b1;
    @(negedge clk);
    heading_rdy = 1'b0;
  endtask

  task automatic line_edge();
    @(negedge clk);
    cntrIR = 1'b1;
    repeat (3) @(negedge clk);
    cntrIR = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    int r0, c0, f0, fc0;
    bit found;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_frwrd", frwrd, 0);
    chk("rst_moving", moving, 0);
    chk("rst_dh", desired_heading, 0);
    chk("rst_send_resp", send_resp, 0);
    chk("rst_strt_cal", strt_cal, 0);
    chk("rst_tour_go", tour_go, 0);
    chk("rst_clr", clr_cmd_rdy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Calibration
    @(negedge clk);
    cmd = 16'h2000;
    cmd_rdy = 1'b1;
    #1;
    chk("cal_clr", clr_cmd_rdy, 1);
    chk("cal_strt", strt_cal, 1);
    chk("cal_no_resp", send_resp, 0);
    @(negedge clk);
    cmd_rdy = 1'b0;
    #1;
    chk("cal_strt_once", strt_cal, 0);
    r0 = resp_cnt;
    repeat (9) @(negedge clk);
    cal_done = 1'b1;
    #1;
    chk("cal_resp", send_resp, 1);
    @(negedge clk);
    cal_done = 1'b0;
    #1;
    chk("cal_resp_drop", send_resp, 0);
    chk("cal_resp_cnt", resp_cnt, r0 + 1);

    // Unknown opcode: consumed, no effect
    r0 = resp_cnt;
    send_cmd(16'h9000, "bad_op_clr");
    repeat (3) @(negedge clk);
    #1;
    chk("bad_op_moving", moving, 0);
    chk("bad_op_no_resp", resp_cnt, r0);

    // One square, heading 0
    heading = 12'h000;
    send_cmd(16'h4001, "m1_clr");
    #1;
    chk("m1_moving", moving, 1);
    chk("m1_dh", desired_heading, 12'h000);
    hpulse();
    #1;
    chk("m1_turn_f0", frwrd, 0);
    repeat (3) hpulse();
    #1;
    chk("m1_ramp3", frwrd, 10'h060);
    repeat (27) hpulse();
    #1;
    chk("m1_sat", frwrd, 10'h300);
    r0 = resp_cnt;
    line_edge();
    #1;
    chk("m1_hold_dn", frwrd, 10'h300);
    chk("m1_still_moving", moving, 1);
    hpulse();
    #1;
    chk("m1_dn1", frwrd, 10'h2C0);
    line_edge();
    repeat (11) hpulse();
    #1;
    chk("m1_dn_zero", frwrd, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("m1_resp", resp_cnt, r0 + 1);
    chk("m1_done", moving, 0);

    // Two squares with heading threshold boundary
    heading = 12'h000;
    send_cmd(16'h43F2, "m2_clr");
    #1;
    chk("m2_dh", desired_heading, 12'h3FF);
    chk("m2_moving", moving, 1);
    repeat (2) hpulse();
    #1;
    chk("m2_turn_f0", frwrd, 0);
    heading = 12'h3CF;
    hpulse();
    heading = 12'h3E0;
    hpulse();
    #1;
    chk("m2_thresh", frwrd, 0);
    repeat (4) hpulse();
    #1;
    chk("m2_ramp4", frwrd, 10'h080);
    line_edge();
    line_edge();
    hpulse();
    #1;
    chk("m2_up_after2", frwrd, 10'h0A0);
    line_edge();
    hpulse();
    #1;
    chk("m2_dn1", frwrd, 10'h060);
    line_edge();
    hpulse();
    #1;
    chk("m2_dn2", frwrd, 10'h020);
    r0 = resp_cnt;
    hpulse();
    #1;
    chk("m2_floor", frwrd, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("m2_resp", resp_cnt, r0 + 1);
    chk("m2_done", moving, 0);

    // Turn only
    heading = 12'h000;
    frwrd_nz = 1'b0;
    r0 = resp_cnt;
    send_cmd(16'h4000, "t0_clr");
    #1;
    chk("t0_moving", moving, 1);
    hpulse();
    repeat (2) @(negedge clk);
    #1;
    chk("t0_resp", resp_cnt, r0 + 1);
    chk("t0_done", moving, 0);
    chk("t0_frwrd_zero", frwrd_nz, 0);

    // Command held while moving
    send_cmd(16'h4001, "h_clr");
    hpulse();
    repeat (2) hpulse();
    #1;
    chk("h_ramp", frwrd, 10'h040);
    @(negedge clk);
    cmd = 16'h6000;
    cmd_rdy = 1'b1;
    #1;
    chk("h_no_clr", clr_cmd_rdy, 0);
    chk("h_no_tour", tour_go, 0);
    c0 = clr_cnt;
    r0 = resp_cnt;
    line_edge();
    hpulse();
    #1;
    chk("h_dn_zero", frwrd, 0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      #1;
      if (clr_cmd_rdy) begin
        found = 1'b1;
        chk("h_clr_held", clr_cnt, c0);
        chk("h_tour", tour_go, 1);
      end
    end
    chk("h_found", found, 1);
    @(negedge clk);
    cmd_rdy = 1'b0;
    #1;
    chk("h_resp", resp_cnt, r0 + 1);
    chk("h_done", moving, 0);

    // Opcode 5
    heading = 12'h000;
    r0 = resp_cnt;
    f0 = ff_cnt;
    fc0 = ff_coinc;
    send_cmd(16'h5001, "f_clr");
    hpulse();
    hpulse();
    #1;
    chk("f_ramp", frwrd, 10'h020);
    line_edge();
    hpulse();
    #1;
    chk("f_dn_zero", frwrd, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("f_resp", resp_cnt, r0 + 1);
`ifdef KNIGHT_FANFARE_EN
    chk("f_fanfare", ff_cnt, f0 + 1);
    chk("f_coinc", ff_coinc, fc0 + 1);
`else
    chk("f_no_fanfare", ff_cnt, f0);
`endif

    // Asynchronous reset mid-ramp
    heading = 12'h10F;
    send_cmd(16'h4101, "r_clr");
    #1;
    chk("r_dh", desired_heading, 12'h10F);
    hpulse();
    repeat (3) hpulse();
    #1;
    chk("r_ramp", frwrd, 10'h060);
    chk("r_moving", moving, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r_async_frwrd", frwrd, 0);
    chk("r_async_moving", moving, 0);
    chk("r_async_dh", desired_heading, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

`ifndef KNIGHT_FANFARE_EN
    chk("fanfare_never", ff_cnt, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
